inst_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the instruction memory. It accepts a byte stream (count byte, little-endian instruction bytes, XOR checksum), assembles bytes into 32-bit words, and issues one-cycle store strobes with word address and data to the instruction memory's store port. It reports `busy`, `done` and `error` so the core is held until a valid program image is resident.

---
 rtl/inst_loader_pkg.sv | 19 +
 rtl/inst_loader_if.sv | 31 +++
 rtl/inst_loader_byte_assembler.sv | 43 ++++
 rtl/inst_loader.sv | 144 ++++++++++++++
 tb/tb_inst_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and width constants for the boot-time instruction loader.
package inst_loader_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ByteW        = 8;
  localparam int unsigned BytesPerWord = XLEN / ByteW;
  localparam int unsigned IdxW         = $clog2(BytesPerWord);

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StBytes,
    StWrite,
    StCheck,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/inst_loader_if.sv
// Byte stream in, instruction-memory store port out.
interface inst_loader_if;

  logic                                rx_valid;
  logic [inst_loader_pkg::ByteW-1:0]   rx_data;
  logic                                rx_ready;
  logic                                store_en;
  logic [inst_loader_pkg::XLEN-1:0]    store_addr;
  logic [inst_loader_pkg::XLEN-1:0]    store_data;

  // Stream source / memory side.
  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  store_en,
    input  store_addr,
    input  store_data
  );

  // Loader side.
  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output store_en,
    output store_addr,
    output store_data
  );

endinterface

// File: rtl/inst_loader_byte_assembler.sv
// Collects little-endian bytes into a word; word_o already includes the byte being accepted.
module inst_loader_byte_assembler
  import inst_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             byte_valid_i,
  input  logic [ByteW-1:0] byte_i,
  output logic [XLEN-1:0]  word_o,
  output logic             word_full_o
);

  logic [XLEN-1:0] word_q, word_d;
  logic [IdxW-1:0] idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (byte_valid_i) begin
      word_d[{idx_q, 3'b000} +: ByteW] = byte_i;
      idx_d                            = idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o      = word_d;
  // High on the cycle the last byte of a word is taken.
  assign word_full_o = byte_valid_i && !clear_i && (idx_q == IdxW'(BytesPerWord - 1));

endmodule

// File: rtl/inst_loader.sv
// Boot loader: count byte, little-endian words, XOR checksum -> instruction memory stores.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned     DEPTH     = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_start_i,
  inst_loader_if.slave bus,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o
);

  localparam int unsigned MaxWords = DEPTH / 4;
  localparam int unsigned WcW      = $clog2(MaxWords) + 1;

  state_e           state_q;
  logic             rx_ready_q;
  logic             store_en_q;
  logic [XLEN-1:0]  store_addr_q;
  logic [XLEN-1:0]  store_data_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [ByteW-1:0] csum_q;
  logic [WcW-1:0]   n_q;
  logic [WcW-1:0]   wcnt_q;

  logic             accept;
  logic             start;
  logic             count_ok;
  logic [WcW-1:0]   wcnt_next;
  logic [XLEN-1:0]  asm_word;
  logic             asm_full;

  assign accept    = bus.rx_valid && rx_ready_q;
  assign start     = load_start_i && (state_q inside {StIdle, StDone, StErr});
  assign count_ok  = (bus.rx_data != '0) && (32'(bus.rx_data) <= MaxWords);
  assign wcnt_next = wcnt_q + WcW'(1);

  inst_loader_byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start),
    .byte_valid_i (accept && (state_q == StBytes)),
    .byte_i       (bus.rx_data),
    .word_o       (asm_word),
    .word_full_o  (asm_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rx_ready_q   <= 1'b0;
      store_en_q   <= 1'b0;
      store_addr_q <= BASE_ADDR;
      store_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      csum_q       <= '0;
      n_q          <= '0;
      wcnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (load_start_i) begin
            state_q      <= StCount;
            rx_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            store_addr_q <= BASE_ADDR;
            csum_q       <= '0;
            n_q          <= '0;
            wcnt_q       <= '0;
          end
        end
        StCount: begin
          if (accept) begin
            if (count_ok) begin
              n_q     <= WcW'(bus.rx_data);
              state_q <= StBytes;
            end else begin
              state_q    <= StErr;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
            end
          end
        end
        StBytes: begin
          if (accept) begin
            csum_q <= csum_q ^ bus.rx_data;
            if (asm_full) begin
              state_q      <= StWrite;
              rx_ready_q   <= 1'b0;
              store_en_q   <= 1'b1;
              store_data_q <= asm_word;
            end
          end
        end
        StWrite: begin
          store_en_q   <= 1'b0;
          store_addr_q <= store_addr_q + XLEN'(4);
          wcnt_q       <= wcnt_next;
          rx_ready_q   <= 1'b1;
          state_q      <= (wcnt_next == n_q) ? StCheck : StBytes;
        end
        StCheck: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (bus.rx_data == csum_q) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              error_q <= 1'b1;
              state_q <= StErr;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          rx_ready_q <= 1'b0;
          store_en_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.store_en   = store_en_q;
  assign bus.store_addr = store_addr_q;
  assign bus.store_data = store_data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: image bytes and expected stores come from a byte-level model.
module tb_inst_loader;

  localparam int unsigned Depth = 32;
  localparam logic [31:0] Base  = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic load_start = 1'b0;
  logic busy, done, error;

  inst_loader_if bus ();

  inst_loader #(
    .DEPTH     (Depth),
    .BASE_ADDR (Base)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  st_t         exp_q[$];
  logic [7:0]  img[$];
  logic [31:0] w[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Every store strobe must match the next word of the image, in order.
  always @(negedge clk) begin
    st_t e;
    if (!rst && bus.store_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_store: addr 0x%08h data 0x%08h, no store expected",
                 bus.store_addr, bus.store_data);
      end else begin
        e = exp_q.pop_front();
        chk("store_addr", bus.store_addr, e.addr);
        chk("store_data", bus.store_data, e.data);
        chk("ready_in_write", 32'(bus.rx_ready), 32'd0);
      end
    end
  end

  // Image = count, words little-endian, XOR of word bytes; queues the stores it should produce.
  task automatic build(input logic [31:0] words[$], input bit corrupt);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    img.delete();
    img.push_back(8'(words.size()));
    for (int i = 0; i < words.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        img.push_back(b);
        cs ^= b;
      end
      exp_q.push_back('{addr: Base + 32'(4 * i), data: words[i]});
    end
    img.push_back(corrupt ? (cs ^ 8'hff) : cs);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int g;
    bit got;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) begin
      bus.rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    got          = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.rx_ready) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL rx_accept: byte 0x%02h not taken within 40 cycles", b);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_load(output int unsigned c0);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    c0 = cyc;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
    chk("start_addr", bus.store_addr, Base);
  endtask

  task automatic run_load(input int gap_max, input int poke, input bit exp_done,
                          input string tag);
    int unsigned c0;
    bit idle;
    start_load(c0);
    for (int i = 0; i < img.size(); i++) begin
      if (i == poke) begin
        bus.rx_valid = 1'b0;
        load_start   = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
      end
      send_byte(img[i], gap_max);
    end
    bus.rx_valid = 1'b0;
    idle = 1'b0;
    for (int k = 0; k < 60 && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) begin
      total++;
      bad++;
      $display("FAIL %s_idle: busy still 1 after 60 cycles", tag);
    end
    // Back-to-back stream: done rises 1 + 5N + 1 cycles after load_start is registered.
    if (gap_max == 0 && poke < 0 && exp_done)
      chk({tag, "_latency"}, cyc - c0, 5 * 32'(img[0]) + 2);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(!exp_done));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int unsigned c0;
    int          n;
    bit          corrupt;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    #12;
    chk("rst_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_store_en", 32'(bus.store_en), 32'd0);
    chk("rst_addr", bus.store_addr, Base);
    chk("rst_data", bus.store_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two-word image; the XOR of its bytes is 0x90.
    w = '{32'h00000013, 32'h00100093};
    build(w, 1'b0);
    chk("model_addr1", exp_q[1].addr, 32'h4);
    chk("model_word1", exp_q[1].data, 32'h00100093);
    chk("model_count", 32'(img[0]), 32'd2);
    chk("model_cs", 32'(img[img.size()-1]), 32'h90);
    run_load(0, -1, 1'b1, "normal");

    img = '{8'd0};
    run_load(0, -1, 1'b0, "cnt0");
    img = '{8'd9};
    run_load(0, -1, 1'b0, "cnt9");

    build(w, 1'b1);
    run_load(0, -1, 1'b0, "badcs");

    build(w, 1'b0);
    run_load(3, -1, 1'b1, "gaps");

    build(w, 1'b0);
    run_load(0, 3, 1'b1, "ignore_start");

    w = '{32'hdeadbeef};
    build(w, 1'b0);
    run_load(0, -1, 1'b1, "restart");

    // Reset after the 6th data byte: word 0 already stored, word 1 never issued.
    w = '{32'h00000013, 32'h00100093};
    build(w, 1'b0);
    start_load(c0);
    for (int i = 0; i < 7; i++) send_byte(img[i], 0);
    bus.rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_ready", 32'(bus.rx_ready), 32'd0);
    chk("mid_store_en", 32'(bus.store_en), 32'd0);
    chk("mid_addr", bus.store_addr, Base);
    chk("mid_data", bus.store_data, 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_error", 32'(error), 32'd0);
    chk("mid_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    build(w, 1'b0);
    run_load(0, -1, 1'b1, "after_rst");

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        img.delete();
        if ($urandom_range(0, 1) == 1) img.push_back(8'd0);
        else img.push_back(8'($urandom_range(Depth / 4 + 1, 255)));
        run_load(2, -1, 1'b0, "rnd_badcnt");
      end else begin
        corrupt = ($urandom_range(0, 3) == 0);
        n = int'($urandom_range(1, Depth / 4));
        w.delete();
        repeat (n) w.push_back($urandom);
        build(w, corrupt);
        run_load(int'($urandom_range(0, 3)), -1, !corrupt, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
